// File: rtl/tmr_pipe_adder.sv
// tmr_pipe_adder: pipelined WIDTH-bit adder (A + B + CIN) with the carry chain
// split into STAGES chunks, one chunk per stage. Every chunk adder is
// triplicated and bitwise-majority voted on {carry, sum}. Disagreeing replicas
// are reported per result, a saturating counter tracks delivered faulty
// results, and a fault-injection port corrupts selected replicas' sum bits.
//
// Ports:
//   IN_CLK, IN_RST_N          clock (rising edge), async active-low reset
//   IN_VALID / OUT_READY      operand handshake (OUT_READY = pipeline advance)
//   IN_A, IN_B, IN_CIN        operands and carry in
//   IN_FI_REPS, IN_FI_MASK    replica select and XOR mask for fault injection
//   OUT_VALID / IN_READY      result handshake
//   OUT_SUM, OUT_COUT         voted sum and carry out
//   OUT_FAULT, OUT_FAULT_REP  any / per-replica disagreement for this result
//   OUT_FAULT_CNT, IN_CNT_CLR saturating faulty-delivery counter and its clear
//
// WIDTH must be divisible by STAGES, STAGES >= 1.
// The three replicas per stage are logically identical; the implementation
// flow must keep them separate (keep/dont_touch on the replica instances).

module tmr_pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             IN_CLK,
  input  logic             IN_RST_N,
  input  logic             IN_VALID,
  output logic             OUT_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic             IN_CIN,
  input  logic [2:0]       IN_FI_REPS,
  input  logic [WIDTH-1:0] IN_FI_MASK,
  output logic             OUT_VALID,
  input  logic             IN_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic             OUT_COUT,
  output logic             OUT_FAULT,
  output logic [2:0]       OUT_FAULT_REP,
  output logic [CNT_W-1:0] OUT_FAULT_CNT,
  input  logic             IN_CNT_CLR
);

  localparam int unsigned CW = WIDTH / STAGES;  // chunk width
  localparam int unsigned RW = CW + 1;          // replica result width {c, sum}
  localparam int unsigned NL = STAGES + 1;      // register levels: capture + one per stage

  // Level l holds a transaction that has passed l adder stages. Level 0 is the
  // capture register; level STAGES drives the outputs. Operand chunks below l
  // are stale (already consumed) and sum chunks at or above l are not yet valid,
  // so the same full-width vectors act as both skew and deskew registers.
  logic [NL-1:0]    vld_q, vld_d;
  logic [NL-1:0]    cy_q, cy_d;
  logic [WIDTH-1:0] a_q    [NL];
  logic [WIDTH-1:0] a_d    [NL];
  logic [WIDTH-1:0] b_q    [NL];
  logic [WIDTH-1:0] b_d    [NL];
  logic [WIDTH-1:0] m_q    [NL];
  logic [WIDTH-1:0] m_d    [NL];
  logic [WIDTH-1:0] sum_q  [NL];
  logic [WIDTH-1:0] sum_d  [NL];
  logic [2:0]       reps_q [NL];
  logic [2:0]       reps_d [NL];
  logic [2:0]       frep_q [NL];
  logic [2:0]       frep_d [NL];
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv_c;
  logic [RW-1:0]    rep_c  [STAGES][3];
  logic [RW-1:0]    vote_c [STAGES];
  logic [2:0]       dis_c  [STAGES];

  function automatic logic [RW-1:0] maj3(input logic [RW-1:0] x,
                                          input logic [RW-1:0] y,
                                          input logic [RW-1:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Global stall: everything moves together when the output slot frees up.
  assign adv_c     = !vld_q[NL-1] || IN_READY;
  assign OUT_READY = adv_c;

  // Triplicated chunk adders, injection on sum bits only, and bitwise vote.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      for (int k = 0; k < 3; k++) begin
        rep_c[s][k] = RW'({1'b0, a_q[s][s*CW +: CW]})
                    + RW'({1'b0, b_q[s][s*CW +: CW]})
                    + RW'(cy_q[s]);
        if (reps_q[s][k]) begin
          rep_c[s][k][CW-1:0] = rep_c[s][k][CW-1:0] ^ m_q[s][s*CW +: CW];
        end
      end
      vote_c[s] = maj3(rep_c[s][0], rep_c[s][1], rep_c[s][2]);
      for (int k = 0; k < 3; k++) begin
        dis_c[s][k] = (rep_c[s][k] != vote_c[s]);
      end
    end
  end

  // Next state: hold by default, shift all levels on advance, update counter.
  always_comb begin
    vld_d   = vld_q;
    cy_d    = cy_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    for (int l = 0; l < NL; l++) begin
      a_d[l]    = a_q[l];
      b_d[l]    = b_q[l];
      m_d[l]    = m_q[l];
      sum_d[l]  = sum_q[l];
      reps_d[l] = reps_q[l];
      frep_d[l] = frep_q[l];
    end

    if (adv_c) begin
      vld_d[0] = IN_VALID;
      if (IN_VALID) begin
        a_d[0]    = IN_A;
        b_d[0]    = IN_B;
        m_d[0]    = IN_FI_MASK;
        cy_d[0]   = IN_CIN;
        reps_d[0] = IN_FI_REPS;
        sum_d[0]  = '0;
        frep_d[0] = '0;
      end
      for (int s = 0; s < STAGES; s++) begin
        vld_d[s+1]                  = vld_q[s];
        a_d[s+1]                    = a_q[s];
        b_d[s+1]                    = b_q[s];
        m_d[s+1]                    = m_q[s];
        reps_d[s+1]                 = reps_q[s];
        sum_d[s+1]                  = sum_q[s];
        sum_d[s+1][s*CW +: CW]      = vote_c[s][CW-1:0];
        cy_d[s+1]                   = vote_c[s][CW];
        frep_d[s+1]                 = frep_q[s] | dis_c[s];
      end
      fault_d = |frep_d[NL-1];
    end

    // Clear has priority over a same-cycle faulty delivery.
    if (IN_CNT_CLR) begin
      cnt_d = '0;
    end else if (vld_q[NL-1] && IN_READY && fault_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      vld_q   <= '0;
      cy_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      for (int l = 0; l < NL; l++) begin
        a_q[l]    <= '0;
        b_q[l]    <= '0;
        m_q[l]    <= '0;
        sum_q[l]  <= '0;
        reps_q[l] <= '0;
        frep_q[l] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      cy_q    <= cy_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      for (int l = 0; l < NL; l++) begin
        a_q[l]    <= a_d[l];
        b_q[l]    <= b_d[l];
        m_q[l]    <= m_d[l];
        sum_q[l]  <= sum_d[l];
        reps_q[l] <= reps_d[l];
        frep_q[l] <= frep_d[l];
      end
    end
  end

  assign OUT_VALID     = vld_q[NL-1];
  assign OUT_SUM       = sum_q[NL-1];
  assign OUT_COUT      = cy_q[NL-1];
  assign OUT_FAULT_REP = frep_q[NL-1];
  assign OUT_FAULT     = fault_q;
  assign OUT_FAULT_CNT = cnt_q;

endmodule
